// File: rtl/mac_accum_pkg.sv
// Shared MAC constants: FSM state encoding used by the accumulator block.
package mac_accum_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_ACCUM = 2'b01,
    ST_HOLD  = 2'b10
  } mac_state_t;

endpackage

// File: rtl/mac_accum_sat_add.sv
// Signed saturating adder: clamps to the signed range of ACC_WIDTH and flags overflow.
module sat_add #(
  parameter int ACC_WIDTH = 40
) (
  input  logic signed [ACC_WIDTH-1:0] iA,
  input  logic signed [ACC_WIDTH-1:0] iB,
  output logic signed [ACC_WIDTH-1:0] oSum,
  output logic                        oOverflow
);

  logic signed [ACC_WIDTH-1:0] w_raw;
  logic signed [ACC_WIDTH-1:0] w_max;
  logic signed [ACC_WIDTH-1:0] w_min;

  assign w_raw = iA + iB;
  assign w_max = {1'b0, {(ACC_WIDTH-1){1'b1}}};
  assign w_min = {1'b1, {(ACC_WIDTH-1){1'b0}}};

  // Overflow only when both operands share a sign and the wrapped sum does not
  assign oOverflow = (iA[ACC_WIDTH-1] == iB[ACC_WIDTH-1]) &&
                     (w_raw[ACC_WIDTH-1] != iA[ACC_WIDTH-1]);

  // Clamp toward the operands' sign on overflow
  always_comb begin
    oSum = w_raw;
    if (oOverflow) begin
      oSum = iA[ACC_WIDTH-1] ? w_min : w_max;
    end else begin
      oSum = w_raw;
    end
  end

endmodule

// File: rtl/mac_accum.sv
// Streaming signed accumulator: sums a valid/ready term sequence with saturation,
// then holds the result until the downstream handshake or an abort.
module mac_accum
  import mac_accum_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ACC_WIDTH  = 40,
  parameter int CNT_WIDTH  = 8
) (
  input  logic                         clk,
  input  logic                         resetn,
  input  logic                         iValid,
  output logic                         oReady,
  input  logic signed [DATA_WIDTH-1:0] iData,
  input  logic                         iLast,
  input  logic                         iClear,
  output logic                         oValid,
  input  logic                         iReady,
  output logic signed [ACC_WIDTH-1:0]  oResult,
  output logic        [CNT_WIDTH-1:0]  oCount,
  output logic                         oOverflow
);

  mac_state_t                   r_state;
  logic                         r_started;
  logic signed [ACC_WIDTH-1:0]  r_acc;
  logic        [CNT_WIDTH-1:0]  r_count;
  logic                         r_ovf;

  logic                         w_accept;
  logic                         w_handoff;
  logic signed [ACC_WIDTH-1:0]  w_term;
  logic signed [ACC_WIDTH-1:0]  w_sum;
  logic                         w_sum_ovf;
  logic        [CNT_WIDTH-1:0]  w_cnt_one;
  logic        [CNT_WIDTH-1:0]  w_cnt_next;

  // r_started keeps oReady low until the first edge after reset release
  assign oReady    = r_started && (r_state != ST_HOLD);
  assign oValid    = (r_state == ST_HOLD);
  assign oResult   = r_acc;
  assign oCount    = r_count;
  assign oOverflow = r_ovf;

  assign w_accept   = iValid && oReady;
  assign w_handoff  = oValid && iReady;
  assign w_term     = {{(ACC_WIDTH-DATA_WIDTH){iData[DATA_WIDTH-1]}}, iData};
  assign w_cnt_one  = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
  assign w_cnt_next = (r_count == {CNT_WIDTH{1'b1}}) ? r_count : (r_count + w_cnt_one);

  sat_add #(.ACC_WIDTH(ACC_WIDTH)) u_sat_add (
    .iA        (r_acc),
    .iB        (w_term),
    .oSum      (w_sum),
    .oOverflow (w_sum_ovf)
  );

  // Sequence FSM and accumulator datapath; iClear overrides every other event
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state   <= ST_IDLE;
      r_started <= 1'b0;
      r_acc     <= '0;
      r_count   <= '0;
      r_ovf     <= 1'b0;
    end else begin
      r_started <= 1'b1;
      if (iClear) begin
        r_state <= ST_IDLE;
        r_acc   <= '0;
        r_count <= '0;
        r_ovf   <= 1'b0;
      end else begin
        case (r_state)
          ST_IDLE: begin
            if (w_accept) begin
              r_acc   <= w_term;
              r_count <= w_cnt_one;
              r_ovf   <= 1'b0;
              r_state <= iLast ? ST_HOLD : ST_ACCUM;
            end
          end
          ST_ACCUM: begin
            if (w_accept) begin
              r_acc   <= w_sum;
              r_count <= w_cnt_next;
              r_ovf   <= r_ovf | w_sum_ovf;
              if (iLast) begin
                r_state <= ST_HOLD;
              end
            end
          end
          ST_HOLD: begin
            // Clearing on handoff keeps the outputs at zero while idle
            if (w_handoff) begin
              r_state <= ST_IDLE;
              r_acc   <= '0;
              r_count <= '0;
              r_ovf   <= 1'b0;
            end
          end
          default: begin
            r_state <= ST_IDLE;
            r_acc   <= '0;
            r_count <= '0;
            r_ovf   <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_mac_accum.sv
// Directed bench for mac_accum: table of term sequences plus hand-written corner cases.
module tb_mac_accum;

  logic               clk;
  logic               resetn;
  logic               iValid;
  logic               oReady;
  logic signed [31:0] iData;
  logic               iLast;
  logic               iClear;
  logic               oValid;
  logic               iReady;
  logic signed [39:0] oResult;
  logic        [7:0]  oCount;
  logic               oOverflow;

  int n_tests = 0;
  int n_fail  = 0;

  mac_accum #(.DATA_WIDTH(32), .ACC_WIDTH(40), .CNT_WIDTH(8)) dut (
    .clk       (clk),
    .resetn    (resetn),
    .iValid    (iValid),
    .oReady    (oReady),
    .iData     (iData),
    .iLast     (iLast),
    .iClear    (iClear),
    .oValid    (oValid),
    .iReady    (iReady),
    .oResult   (oResult),
    .oCount    (oCount),
    .oOverflow (oOverflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int     n;
    int     d[4];
    longint exp_res;
    int     exp_cnt;
    bit     exp_ovf;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int d, input bit last);
    iValid = 1'b1;
    iData  = d;
    iLast  = last;
    tick();
    iValid = 1'b0;
    iLast  = 1'b0;
  endtask

  task automatic handoff();
    iReady = 1'b1;
    tick();
    iReady = 1'b0;
    chk("handoff_valid", {63'd0, oValid}, 64'd0);
    chk("idle_result",   64'(oResult), 64'd0);
    chk("idle_count",    {56'd0, oCount}, 64'd0);
  endtask

  task automatic send_many(input int n, input int d, input int last_d);
    for (int k = 0; k < n; k++) send(d, 1'b0);
    send(last_d, 1'b1);
  endtask

  initial begin
    logic signed [39:0] exp40;

    vecs[0] = '{1, '{5, 0, 0, 0}, 64'sd5, 1, 1'b0};
    vecs[1] = '{3, '{10, -3, 7, 0}, 64'sd14, 3, 1'b0};
    vecs[2] = '{2, '{-100, 50, 0, 0}, -64'sd50, 2, 1'b0};
    vecs[3] = '{3, '{32'h80000000, 32'h80000000, 1, 0}, -64'sd4294967295, 3, 1'b0};
    vecs[4] = '{4, '{-1, -1, -1, -1}, -64'sd4, 4, 1'b0};
    vecs[5] = '{4, '{32'h7FFFFFFF, 32'h7FFFFFFF, -2, 0}, 64'sd4294967292, 4, 1'b0};

    resetn = 1'b0; iValid = 1'b0; iData = '0; iLast = 1'b0; iClear = 1'b0; iReady = 1'b0;
    tick();
    chk("rst_ready",  {63'd0, oReady}, 64'd0);
    chk("rst_valid",  {63'd0, oValid}, 64'd0);
    chk("rst_result", 64'(oResult), 64'd0);
    chk("rst_count",  {56'd0, oCount}, 64'd0);
    chk("rst_ovf",    {63'd0, oOverflow}, 64'd0);
    @(negedge clk);
    resetn = 1'b1;
    #1;
    chk("ready_before_edge", {63'd0, oReady}, 64'd0);
    tick();
    chk("ready_after_edge", {63'd0, oReady}, 64'd1);

    for (int i = 0; i < 6; i++) begin
      for (int j = 0; j < vecs[i].n; j++) begin
        chk($sformatf("v%0d_ready%0d", i, j), {63'd0, oReady}, 64'd1);
        chk($sformatf("v%0d_early_valid%0d", i, j), {63'd0, oValid}, 64'd0);
        send(vecs[i].d[j], (j == vecs[i].n - 1));
      end
      exp40 = 40'(vecs[i].exp_res);
      chk($sformatf("v%0d_valid", i),  {63'd0, oValid}, 64'd1);
      chk($sformatf("v%0d_result", i), 64'(oResult), 64'(exp40));
      chk($sformatf("v%0d_count", i),  {56'd0, oCount}, 64'(vecs[i].exp_cnt));
      chk($sformatf("v%0d_ovf", i),    {63'd0, oOverflow}, {63'd0, vecs[i].exp_ovf});
      handoff();
    end

    // HOLD stall with iValid high: nothing absorbed
    send(42, 1'b1);
    iValid = 1'b1; iData = 99; iReady = 1'b0;
    for (int c = 0; c < 10; c++) begin
      tick();
      chk("stall_result", 64'(oResult), 64'd42);
      chk("stall_ready",  {63'd0, oReady}, 64'd0);
      chk("stall_count",  {56'd0, oCount}, 64'd1);
      chk("stall_valid",  {63'd0, oValid}, 64'd1);
    end
    iValid = 1'b0;
    handoff();
    chk("stall_ready_after", {63'd0, oReady}, 64'd1);

    // Clear with a simultaneous term discards everything
    send(3, 1'b0);
    send(9, 1'b0);
    iClear = 1'b1; iValid = 1'b1; iData = 8;
    tick();
    iClear = 1'b0; iValid = 1'b0;
    chk("clr_result", 64'(oResult), 64'd0);
    chk("clr_count",  {56'd0, oCount}, 64'd0);
    send(4, 1'b1);
    chk("clr_valid",   {63'd0, oValid}, 64'd1);
    chk("clr_result2", 64'(oResult), 64'd4);
    chk("clr_count2",  {56'd0, oCount}, 64'd1);
    handoff();

    // Positive saturation, count saturates at 255
    send_many(299, 32'h7FFFFFFF, 32'h7FFFFFFF);
    chk("psat_result", 64'(oResult), 64'h0000_007F_FFFF_FFFF);
    chk("psat_ovf",    {63'd0, oOverflow}, 64'd1);
    chk("psat_count",  {56'd0, oCount}, 64'd255);
    handoff();
    chk("psat_ovf_cleared", {63'd0, oOverflow}, 64'd0);

    // Negative saturation (exact minimum at 256 terms, overflow after)
    send_many(299, 32'h80000000, 32'h80000000);
    exp40 = 40'h80_0000_0000;
    chk("nsat_result", 64'(oResult), 64'(exp40));
    chk("nsat_ovf",    {63'd0, oOverflow}, 64'd1);
    chk("nsat_count",  {56'd0, oCount}, 64'd255);
    handoff();

    // Overflow flag stays set after the sum backs off the limit
    send_many(260, 32'h7FFFFFFF, -5);
    chk("sticky_result", 64'(oResult), 64'h0000_007F_FFFF_FFFA);
    chk("sticky_ovf",    {63'd0, oOverflow}, 64'd1);
    handoff();

    // Clear in HOLD drops the pending result
    send(7, 1'b1);
    iClear = 1'b1;
    tick();
    iClear = 1'b0;
    chk("hclr_valid",  {63'd0, oValid}, 64'd0);
    chk("hclr_result", 64'(oResult), 64'd0);
    chk("hclr_ready",  {63'd0, oReady}, 64'd1);

    // Reset pulse between edges while in HOLD
    send(5, 1'b1);
    #2;
    resetn = 1'b0;
    #1;
    chk("arst_valid",  {63'd0, oValid}, 64'd0);
    chk("arst_result", 64'(oResult), 64'd0);
    chk("arst_count",  {56'd0, oCount}, 64'd0);
    chk("arst_ready",  {63'd0, oReady}, 64'd0);
    resetn = 1'b1;
    tick();
    chk("arst_ready_back", {63'd0, oReady}, 64'd1);
    send(-6, 1'b1);
    exp40 = -40'sd6;
    chk("post_rst_result", 64'(oResult), 64'(exp40));
    chk("post_rst_count",  {56'd0, oCount}, 64'd1);
    handoff();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
